mmcm_drp_reconfig: RTL

Dynamic-reconfiguration controller that sits directly upstream of an MMCME2_ADV and drives its DRP port. On a start request it holds the MMCM in reset, read-modify-writes a table of DRP registers (selected from two stored configurations), releases reset and waits for LOCKED. It lets primitive tests switch MMCM output frequencies at run time without a new bitstream.

---
 rtl/mmcm_drp_pkg.sv | 47 ++++
 rtl/mmcm_drp_if.sv | 14 +
 rtl/mmcm_drp_rom.sv | 29 ++
 rtl/mmcm_drp_reconfig.sv | 107 ++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types and MMCME2_ADV DRP register map for the reconfiguration controller.
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ASSERT_RST,
        ST_READ,
        ST_WAIT_RD,
        ST_MODIFY,
        ST_WRITE,
        ST_WAIT_WR,
        ST_RELEASE,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // One table row: register address, bits to preserve, bits to set.
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] bits;
    } rom_entry_t;

    localparam logic [6:0] ADDR_CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_REG2  = 7'h09;
    localparam logic [6:0] ADDR_CLKOUT1_REG1  = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT1_REG2  = 7'h0B;
    localparam logic [6:0] ADDR_CLKOUT2_REG1  = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT2_REG2  = 7'h0D;
    localparam logic [6:0] ADDR_CLKOUT3_REG1  = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT3_REG2  = 7'h0F;
    localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] ADDR_CLKFBOUT_REG2 = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK        = 7'h16;
    localparam logic [6:0] ADDR_LOCK_REG1     = 7'h18;
    localparam logic [6:0] ADDR_LOCK_REG2     = 7'h19;
    localparam logic [6:0] ADDR_LOCK_REG3     = 7'h1A;
    localparam logic [6:0] ADDR_FILT_REG1     = 7'h4E;
    localparam logic [6:0] ADDR_FILT_REG2     = 7'h4F;

    function automatic logic [15:0] rmw(input logic [15:0] rd, input logic [15:0] mask,
                                        input logic [15:0] bits);
        return (rd & mask) | bits;
    endfunction

endpackage

// File: rtl/mmcm_drp_if.sv
// DRP bus between the reconfiguration controller (master) and the MMCM (slave).
// Handshake: den is a one-cycle request (dwe marks a write); the slave answers with a one-cycle
// drdy no earlier than the following cycle; daddr/di hold from den until drdy.
interface mmcm_drp_if;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        den;
    logic        dwe;
    logic        drdy;

    modport master (output daddr, di, den, dwe, input dout, drdy);
    modport slave  (input daddr, di, den, dwe, output dout, drdy);
endinterface

// File: rtl/mmcm_drp_rom.sv
// Two stored MMCM configurations, indexed by {sel, idx}; purely combinational.
module mmcm_drp_rom
    import mmcm_drp_pkg::*;
#(
    parameter int IW = 3
) (
    input  logic          sel,
    input  logic [IW-1:0] idx,
    output rom_entry_t    entry
);
    logic [4:0] row;

    always_comb begin
        row = 5'(idx);
        // Rows past the table re-write FILT2 with its own value, a harmless no-op access.
        entry = '{ADDR_FILT_REG2, 16'hFFFF, 16'h0000};
        case (row)
            5'd0: entry = '{ADDR_CLKOUT0_REG1,  16'h1000, sel ? 16'h0082 : 16'h0145};
            5'd1: entry = '{ADDR_CLKOUT0_REG2,  16'hFC00, sel ? 16'h0080 : 16'h0000};
            5'd2: entry = '{ADDR_CLKOUT1_REG1,  16'h1000, sel ? 16'h0104 : 16'h0208};
            5'd3: entry = '{ADDR_CLKOUT1_REG2,  16'hFC00, 16'h0000};
            5'd4: entry = '{ADDR_CLKFBOUT_REG1, 16'h1000, sel ? 16'h0410 : 16'h0514};
            5'd5: entry = '{ADDR_CLKFBOUT_REG2, 16'hFC00, sel ? 16'h0080 : 16'h0000};
            5'd6: entry = '{ADDR_DIVCLK,        16'hC000, 16'h1041};
            5'd7: entry = '{ADDR_FILT_REG1,     16'h66FF, sel ? 16'h9000 : 16'h0800};
            default: ;
        endcase
    end
endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Drives an MMCME2_ADV DRP port: holds the MMCM in reset, read-modify-writes one of two
// stored register tables, then releases reset and waits for LOCKED.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    mmcm_drp_if.master drp,
    output logic       mmcm_rst,
    input  logic       locked,
    output state_t     state_dbg
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    state_t        state, next_state;
    logic          sel_q;
    logic [IW-1:0] idx;
    logic [15:0]   tmo_cnt;
    logic [15:0]   rd_data;
    logic [15:0]   wr_data;
    logic [1:0]    lock_sync;
    rom_entry_t    entry;
    logic          last, access, drdy_tmo, lock_tmo;

    mmcm_drp_rom #(.IW(IW)) u_rom (.sel(sel_q), .idx(idx), .entry(entry));

    assign last      = (idx == IW'(NUM_ENTRIES - 1));
    assign access    = state inside {ST_READ, ST_WAIT_RD, ST_MODIFY, ST_WRITE, ST_WAIT_WR};
    assign drdy_tmo  = (tmo_cnt == 16'(DRDY_TIMEOUT));
    assign lock_tmo  = (tmo_cnt == 16'(LOCK_TIMEOUT));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign drp.den   = (state == ST_READ) || (state == ST_WRITE);
    assign drp.dwe   = (state == ST_WRITE);
    assign drp.daddr = access ? entry.addr : 7'd0;
    assign drp.di    = wr_data;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (start) next_state = ST_ASSERT_RST;
            ST_ASSERT_RST: next_state = ST_READ;
            ST_READ:       next_state = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (drp.drdy)     next_state = ST_MODIFY;
                else if (drdy_tmo) next_state = ST_ERROR;
            end
            ST_MODIFY:     next_state = ST_WRITE;
            ST_WRITE:      next_state = ST_WAIT_WR;
            ST_WAIT_WR: begin
                if (drp.drdy)     next_state = last ? ST_RELEASE : ST_READ;
                else if (drdy_tmo) next_state = ST_ERROR;
            end
            ST_RELEASE:    next_state = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_sync[1]) next_state = ST_DONE;
                else if (lock_tmo) next_state = ST_ERROR;
            end
            ST_DONE:       next_state = ST_IDLE;
            ST_ERROR:      next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            idx       <= '0;
            tmo_cnt   <= 16'd0;
            rd_data   <= 16'd0;
            wr_data   <= 16'd0;
            lock_sync <= 2'b00;
            error     <= 1'b0;
            mmcm_rst  <= 1'b1;
        end else begin
            lock_sync <= {lock_sync[0], locked};
            // One counter serves both timeouts because it restarts on every state change.
            tmo_cnt   <= (next_state != state) ? 16'd0 : tmo_cnt + 16'd1;
            mmcm_rst  <= next_state inside {ST_ASSERT_RST, ST_READ, ST_WAIT_RD,
                                            ST_MODIFY, ST_WRITE, ST_WAIT_WR};
            if (state == ST_IDLE && start) begin
                sel_q <= sel;
                idx   <= '0;
                error <= 1'b0;
            end
            if (next_state == ST_ERROR) error <= 1'b1;
            if (state == ST_WAIT_RD && drp.drdy) rd_data <= drp.dout;
            if (state == ST_MODIFY) wr_data <= rmw(rd_data, entry.mask, entry.bits);
            if (state == ST_WAIT_WR && drp.drdy && !last) idx <= idx + 1'b1;
        end
    end
endmodule
